gbemac_rx_stream_checker: RTL and testbench



---
 rtl/gbemac_rx_chk_pkg.sv | 22 ++
 rtl/gbemac_rx_chk_sat_counter.sv | 31 +++
 rtl/gbemac_rx_stream_checker.sv | 157 +++++++++++++++
 tb/tb_gbemac_rx_stream_checker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gbemac_rx_chk_pkg.sv
// Shared types, default widths and the saturating-increment helper for the
// GbemacWrapperBlock receive-stream checker.
package gbemac_rx_chk_pkg;

    typedef enum logic {
        SEEK = 1'b0,
        LOCK = 1'b1
    } chk_state_e;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CNT_W  = 32;
    localparam int DEFAULT_LEN_W  = 16;
    localparam int DEFAULT_GAP_W  = 32;

    // Increment v, holding at the all-ones value of a w-bit field (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/gbemac_rx_chk_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import gbemac_rx_chk_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = W'(sat_inc(64'(cnt_q), W));
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/gbemac_rx_stream_checker.sv
// Receive-stream checker: verifies an incrementing word sequence and keeps
// registered word/packet/error/length/gap statistics for the debug path.
module gbemac_rx_stream_checker
    import gbemac_rx_chk_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int LEN_W  = DEFAULT_LEN_W,
    parameter int GAP_W  = DEFAULT_GAP_W
) (
    input  logic              clk,
    input  logic              glbl_rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              stall,
    input  logic              clr,
    output logic              locked,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_got,
    output logic [LEN_W-1:0]  last_pkt_len,
    output logic              len_ovf,
    output logic [GAP_W-1:0]  gap_max
);

    // Stream handshake: a beat transfers on any rising edge where s_valid and
    // s_ready are both high; s_data/s_last are only meaningful with s_valid.
    chk_state_e        state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;
    logic [DATA_W-1:0] err_got_q, err_got_d;
    logic [LEN_W-1:0]  last_pkt_len_q, last_pkt_len_d;
    logic              len_ovf_q, len_ovf_d;
    logic [GAP_W-1:0]  gap_max_q, gap_max_d;

    logic              accept;
    logic              mismatch;
    logic              stats_clr;
    logic [LEN_W-1:0]  pkt_len;
    logic [GAP_W-1:0]  gap_cnt;

    assign accept    = s_valid && s_ready_q;
    assign mismatch  = accept && (state_q == LOCK) && (s_data != expected_q);
    assign stats_clr = glbl_rst || clr;

    sat_counter #(.W(CNT_W)) u_word_cnt (
        .clk (clk),
        .clr (stats_clr),
        .inc (accept),
        .q   (word_count)
    );

    sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk (clk),
        .clr (stats_clr),
        .inc (accept && s_last),
        .q   (pkt_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .clr (stats_clr),
        .inc (mismatch),
        .q   (err_count)
    );

    // A closing beat restarts the running length at zero.
    sat_counter #(.W(LEN_W)) u_pkt_len (
        .clk (clk),
        .clr (stats_clr || (accept && s_last)),
        .inc (accept),
        .q   (pkt_len)
    );

    sat_counter #(.W(GAP_W)) u_gap_cnt (
        .clk (clk),
        .clr (stats_clr || accept),
        .inc (state_q == LOCK),
        .q   (gap_cnt)
    );

    always_comb begin
        state_d        = state_q;
        s_ready_d      = ~stall;
        expected_d     = expected_q;
        err_exp_d      = err_exp_q;
        err_got_d      = err_got_q;
        last_pkt_len_d = last_pkt_len_q;
        len_ovf_d      = len_ovf_q;
        gap_max_d      = gap_max_q;

        if (clr) begin
            state_d        = SEEK;
            expected_d     = '0;
            err_exp_d      = '0;
            err_got_d      = '0;
            last_pkt_len_d = '0;
            len_ovf_d      = 1'b0;
            gap_max_d      = '0;
        end else if (accept) begin
            // Always resync to the received word, so one bad word costs one error.
            expected_d = s_data + DATA_W'(1);
            if (state_q == SEEK) begin
                state_d = LOCK;
            end else if (mismatch) begin
                err_exp_d = expected_q;
                err_got_d = s_data;
            end
            if (s_last) begin
                last_pkt_len_d = LEN_W'(sat_inc(64'(pkt_len), LEN_W));
            end
            // Length already saturated: this beat makes the packet too long.
            if (pkt_len == '1) begin
                len_ovf_d = 1'b1;
            end
            if (gap_cnt > gap_max_q) begin
                gap_max_d = gap_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (glbl_rst) begin
            state_q        <= SEEK;
            s_ready_q      <= 1'b0;
            expected_q     <= '0;
            err_exp_q      <= '0;
            err_got_q      <= '0;
            last_pkt_len_q <= '0;
            len_ovf_q      <= 1'b0;
            gap_max_q      <= '0;
        end else begin
            state_q        <= state_d;
            s_ready_q      <= s_ready_d;
            expected_q     <= expected_d;
            err_exp_q      <= err_exp_d;
            err_got_q      <= err_got_d;
            last_pkt_len_q <= last_pkt_len_d;
            len_ovf_q      <= len_ovf_d;
            gap_max_q      <= gap_max_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign locked       = (state_q == LOCK);
    assign err_exp      = err_exp_q;
    assign err_got      = err_got_q;
    assign last_pkt_len = last_pkt_len_q;
    assign len_ovf      = len_ovf_q;
    assign gap_max      = gap_max_q;

endmodule

// File: tb/tb_gbemac_rx_stream_checker.sv
// Directed bench for gbemac_rx_stream_checker; a second instance with a
// 4-bit length counter shares the stimulus for the overflow scenario.
module tb_gbemac_rx_stream_checker;

    logic        clk = 1'b0;
    logic        glbl_rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        stall;
    logic        clr;

    logic        s_ready, locked, len_ovf;
    logic [31:0] word_count, pkt_count, err_count, err_exp, err_got, gap_max;
    logic [15:0] last_pkt_len;

    logic        s_ready_s, locked_s, len_ovf_s;
    logic [31:0] word_count_s, pkt_count_s, err_count_s, err_exp_s, err_got_s, gap_max_s;
    logic [3:0]  last_pkt_len_s;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    gbemac_rx_stream_checker dut (
        .clk(clk), .glbl_rst(glbl_rst), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .stall(stall), .clr(clr),
        .locked(locked), .word_count(word_count), .pkt_count(pkt_count),
        .err_count(err_count), .err_exp(err_exp), .err_got(err_got),
        .last_pkt_len(last_pkt_len), .len_ovf(len_ovf), .gap_max(gap_max)
    );

    gbemac_rx_stream_checker #(.LEN_W(4)) dut_len4 (
        .clk(clk), .glbl_rst(glbl_rst), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready_s), .stall(stall), .clr(clr),
        .locked(locked_s), .word_count(word_count_s), .pkt_count(pkt_count_s),
        .err_count(err_count_s), .err_exp(err_exp_s), .err_got(err_got_s),
        .last_pkt_len(last_pkt_len_s), .len_ovf(len_ovf_s), .gap_max(gap_max_s)
    );

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (!s_ready) $display("FAIL send_beat_timeout got s_ready=%0b exp 1 data=%h", s_ready, d);
        else n_pass++;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        glbl_rst = 1'b1;
        stall = 1'b0; clr = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        n_total++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %0b exp 0", s_ready); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL rst_locked got %0b exp 0", locked); else n_pass++;
        n_total++; if (word_count !== 32'd0) $display("FAIL rst_word_count got %0d exp 0", word_count); else n_pass++;
        n_total++; if (last_pkt_len !== 16'd0) $display("FAIL rst_last_pkt_len got %0d exp 0", last_pkt_len); else n_pass++;
        n_total++; if (len_ovf !== 1'b0) $display("FAIL rst_len_ovf got %0b exp 0", len_ovf); else n_pass++;
        glbl_rst = 1'b0;
        @(negedge clk);
        n_total++; if (s_ready !== 1'b1) $display("FAIL rst_release_s_ready got %0b exp 1", s_ready); else n_pass++;
    endtask

    task automatic test_continuous();
        for (int i = 0; i < 256; i++) send_beat(32'(i), (i % 64) == 63);
        n_total++; if (word_count !== 32'd256) $display("FAIL cont_word_count got %0d exp 256", word_count); else n_pass++;
        n_total++; if (pkt_count !== 32'd4) $display("FAIL cont_pkt_count got %0d exp 4", pkt_count); else n_pass++;
        n_total++; if (last_pkt_len !== 16'd64) $display("FAIL cont_last_pkt_len got %0d exp 64", last_pkt_len); else n_pass++;
        n_total++; if (err_count !== 32'd0) $display("FAIL cont_err_count got %0d exp 0", err_count); else n_pass++;
        n_total++; if (locked !== 1'b1) $display("FAIL cont_locked got %0b exp 1", locked); else n_pass++;
        n_total++; if (gap_max !== 32'd0) $display("FAIL cont_gap_max got %0d exp 0", gap_max); else n_pass++;
    endtask

    task automatic test_mismatch();
        pulse_clr();
        send_beat(32'h1C55, 1'b0);
        send_beat(32'h1C56, 1'b0);
        send_beat(32'h1C89, 1'b0);
        n_total++; if (err_count !== 32'd1) $display("FAIL mis_err_count got %0d exp 1", err_count); else n_pass++;
        send_beat(32'h1C8A, 1'b0);
        n_total++; if (err_count !== 32'd1) $display("FAIL mis_resync_err_count got %0d exp 1", err_count); else n_pass++;
        n_total++; if (err_exp !== 32'h1C57) $display("FAIL mis_err_exp got %h exp 00001c57", err_exp); else n_pass++;
        n_total++; if (err_got !== 32'h1C89) $display("FAIL mis_err_got got %h exp 00001c89", err_got); else n_pass++;
        n_total++; if (word_count !== 32'd4) $display("FAIL mis_word_count got %0d exp 4", word_count); else n_pass++;
    endtask

    task automatic test_wrap();
        pulse_clr();
        n_total++; if (locked !== 1'b0) $display("FAIL wrap_clr_locked got %0b exp 0", locked); else n_pass++;
        send_beat(32'hFFFF_FFFE, 1'b0);
        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(32'h0000_0000, 1'b0);
        send_beat(32'h0000_0001, 1'b0);
        n_total++; if (err_count !== 32'd0) $display("FAIL wrap_err_count got %0d exp 0", err_count); else n_pass++;
        n_total++; if (word_count !== 32'd4) $display("FAIL wrap_word_count got %0d exp 4", word_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        send_beat(32'h2, 1'b0);
        stall = 1'b1;
        @(negedge clk);
        n_total++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready got %0b exp 0", s_ready); else n_pass++;
        s_valid = 1'b1;
        s_data  = 32'h3;
        repeat (10) @(negedge clk);
        n_total++; if (word_count !== 32'd5) $display("FAIL bp_word_count_stalled got %0d exp 5", word_count); else n_pass++;
        stall = 1'b0;
        send_beat(32'h3, 1'b0);
        n_total++; if (word_count !== 32'd6) $display("FAIL bp_word_count got %0d exp 6", word_count); else n_pass++;
        n_total++; if (err_count !== 32'd0) $display("FAIL bp_err_count got %0d exp 0", err_count); else n_pass++;
    endtask

    task automatic test_gap();
        pulse_clr();
        send_beat(32'h10, 1'b0);
        send_beat(32'h11, 1'b0);
        repeat (1000) @(negedge clk);
        send_beat(32'h12, 1'b0);
        n_total++; if (gap_max !== 32'd1000) $display("FAIL gap_max got %0d exp 1000", gap_max); else n_pass++;
        n_total++; if (err_count !== 32'd0) $display("FAIL gap_err_count got %0d exp 0", err_count); else n_pass++;
    endtask

    task automatic test_clear_coincident();
        send_beat(32'h13, 1'b1);
        send_beat(32'h20, 1'b0);
        n_total++; if (err_count !== 32'd1) $display("FAIL clrc_pre_err_count got %0d exp 1", err_count); else n_pass++;
        s_valid = 1'b1;
        s_data  = 32'h99;
        s_last  = 1'b1;
        clr     = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_total++; if (word_count !== 32'd0) $display("FAIL clrc_word_count got %0d exp 0", word_count); else n_pass++;
        n_total++; if (pkt_count !== 32'd0) $display("FAIL clrc_pkt_count got %0d exp 0", pkt_count); else n_pass++;
        n_total++; if (err_count !== 32'd0) $display("FAIL clrc_err_count got %0d exp 0", err_count); else n_pass++;
        n_total++; if (err_exp !== 32'd0 || err_got !== 32'd0) $display("FAIL clrc_err_capture got %h/%h exp 0/0", err_exp, err_got); else n_pass++;
        n_total++; if (last_pkt_len !== 16'd0) $display("FAIL clrc_last_pkt_len got %0d exp 0", last_pkt_len); else n_pass++;
        n_total++; if (gap_max !== 32'd0) $display("FAIL clrc_gap_max got %0d exp 0", gap_max); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL clrc_locked got %0b exp 0", locked); else n_pass++;
        send_beat(32'h5, 1'b0);
        n_total++; if (locked !== 1'b1 || err_count !== 32'd0) $display("FAIL clrc_relock got locked=%0b err=%0d exp 1/0", locked, err_count); else n_pass++;
        send_beat(32'h7, 1'b0);
        n_total++; if (err_count !== 32'd1) $display("FAIL clrc_err_count_after got %0d exp 1", err_count); else n_pass++;
        n_total++; if (err_exp !== 32'h6) $display("FAIL clrc_err_exp got %h exp 00000006", err_exp); else n_pass++;
        n_total++; if (err_got !== 32'h7) $display("FAIL clrc_err_got got %h exp 00000007", err_got); else n_pass++;
    endtask

    task automatic test_len_ovf();
        pulse_clr();
        for (int i = 0; i < 16; i++) send_beat(32'(i), 1'b0);
        n_total++; if (len_ovf_s !== 1'b1) $display("FAIL len4_ovf got %0b exp 1", len_ovf_s); else n_pass++;
        n_total++; if (len_ovf !== 1'b0) $display("FAIL len16_ovf got %0b exp 0", len_ovf); else n_pass++;
        n_total++; if (pkt_count_s !== 32'd0) $display("FAIL len4_pkt_count_open got %0d exp 0", pkt_count_s); else n_pass++;
        send_beat(32'd16, 1'b1);
        n_total++; if (last_pkt_len_s !== 4'd15) $display("FAIL len4_last_pkt_len got %0d exp 15", last_pkt_len_s); else n_pass++;
        n_total++; if (pkt_count_s !== 32'd1) $display("FAIL len4_pkt_count got %0d exp 1", pkt_count_s); else n_pass++;
        n_total++; if (last_pkt_len !== 16'd17) $display("FAIL len16_last_pkt_len got %0d exp 17", last_pkt_len); else n_pass++;
        n_total++; if (len_ovf_s !== 1'b1) $display("FAIL len4_ovf_sticky got %0b exp 1", len_ovf_s); else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        send_beat(32'd17, 1'b0);
        glbl_rst = 1'b1;
        @(negedge clk);
        glbl_rst = 1'b0;
        @(negedge clk);
        n_total++; if (len_ovf_s !== 1'b0 || locked !== 1'b0) $display("FAIL rstmid_state got ovf=%0b locked=%0b exp 0/0", len_ovf_s, locked); else n_pass++;
        send_beat(32'h40, 1'b1);
        n_total++; if (last_pkt_len !== 16'd1 || pkt_count !== 32'd1) $display("FAIL rstmid_seek_last got len=%0d pkts=%0d exp 1/1", last_pkt_len, pkt_count); else n_pass++;
        n_total++; if (err_count !== 32'd0 || locked !== 1'b1) $display("FAIL rstmid_sync got err=%0d locked=%0b exp 0/1", err_count, locked); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_mismatch();
        test_wrap();
        test_backpressure();
        test_gap();
        test_clear_coincident();
        test_len_ovf();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
